// File: rtl/serial_gate_pkg.sv
// Shared types for the mux-only bit-serial logic unit.
package serial_gate_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

endpackage

// File: rtl/mux2_cell.sv
// 2:1 mux cell, y = sel ? d1 : d0; the only combinational primitive of the unit.
module mux2_cell (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/serial_gate_unit_using_mux.sv
// Bit-serial AND/OR/XOR/NAND unit: operands latched on accept, evaluated LSB first
// through mux cells, result held under a valid/ready handshake.
module serial_gate_unit_using_mux
  import serial_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nx;
  op_t              op_q;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] a_sr, b_sr, result_sr;
  logic [CW-1:0]    cnt;
  logic             accept, shift_en;

  logic a_bit, b_bit, not_b, and_y, or_y, xor_y, nand_y, sel_lo, sel_hi, gate_y;

  assign a_bit  = a_sr[0];
  assign b_bit  = b_sr[0];
  assign op_sel = op_q;

  mux2_cell u_not_b (.d0(1'b1),  .d1(1'b0),  .sel(b_bit),  .y(not_b));
  mux2_cell u_and   (.d0(1'b0),  .d1(b_bit), .sel(a_bit),  .y(and_y));
  mux2_cell u_or    (.d0(a_bit), .d1(1'b1),  .sel(b_bit),  .y(or_y));
  mux2_cell u_xor   (.d0(b_bit), .d1(not_b), .sel(a_bit),  .y(xor_y));
  mux2_cell u_nand  (.d0(1'b1),  .d1(1'b0),  .sel(and_y),  .y(nand_y));

  // opcode decode as a 4:1 tree: op[0] picks within a pair, op[1] picks the pair
  mux2_cell u_sel_lo (.d0(and_y),  .d1(or_y),   .sel(op_sel[0]), .y(sel_lo));
  mux2_cell u_sel_hi (.d0(xor_y),  .d1(nand_y), .sel(op_sel[0]), .y(sel_hi));
  mux2_cell u_sel    (.d0(sel_lo), .d1(sel_hi), .sel(op_sel[1]), .y(gate_y));

  always_comb begin
    state_nx   = state;
    up_ready   = 1'b0;
    down_valid = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        up_ready = 1'b1;
        if (up_valid) begin
          accept   = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        if (cnt == LAST) state_nx = HOLD;
      end
      HOLD: begin
        busy       = 1'b1;
        down_valid = 1'b1;
        if (down_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= OP_AND;
      a_sr      <= '0;
      b_sr      <= '0;
      result_sr <= '0;
      cnt       <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_sr <= a;
        b_sr <= b;
        op_q <= op_t'(op);
        cnt  <= '0;
      end else if (shift_en) begin
        // operands shift down so bit cnt is always at position 0
        a_sr      <= {1'b0, a_sr[WIDTH-1:1]};
        b_sr      <= {1'b0, b_sr[WIDTH-1:1]};
        result_sr <= {gate_y, result_sr[WIDTH-1:1]};
        if (cnt != LAST) cnt <= cnt + CW'(1);
      end
    end
  end

  assign result = result_sr;

endmodule

// File: tb/tb_serial_gate_unit_using_mux.sv
// Self-checking bench: a cycle-level behavioural model of the handshake plus
// directed literal pins, randomized traffic and an exhaustive 2-bit build.
module tb_serial_gate_unit_using_mux;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         up_valid = 1'b0;
  logic         down_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   op = '0;
  logic         up_ready, down_valid, busy;
  logic [W-1:0] result;

  logic         rst2_n = 1'b0;
  logic         up_valid2 = 1'b0;
  logic         down_ready2 = 1'b0;
  logic [1:0]   a2 = '0;
  logic [1:0]   b2 = '0;
  logic [1:0]   op2 = '0;
  logic         up_ready2, down_valid2, busy2;
  logic [1:0]   result2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_gate_unit_using_mux #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_ready(up_ready),
    .a(a), .b(b), .op(op), .down_valid(down_valid), .down_ready(down_ready),
    .result(result), .busy(busy)
  );

  serial_gate_unit_using_mux #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .up_valid(up_valid2), .up_ready(up_ready2),
    .a(a2), .b(b2), .op(op2), .down_valid(down_valid2), .down_ready(down_ready2),
    .result(result2), .busy(busy2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_gate(input logic [31:0] x, input logic [31:0] y,
                                           input logic [1:0] o);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  // Model: an accepted pair is pending until released; its result appears W edges
  // after accept and stays known until the next accept.
  logic         m_pending = 1'b0;
  int           m_cyc = 0;
  logic [W-1:0] m_res = '0;
  logic         m_known = 1'b1;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_pending = 1'b0;
      m_cyc     = 0;
      m_res     = '0;
    end else if (!m_pending) begin
      if (up_valid) begin
        m_pending = 1'b1;
        m_cyc     = 0;
        m_res     = W'(ref_gate(32'(a), 32'(b), op));
      end
    end else if (m_cyc < W) begin
      m_cyc = m_cyc + 1;
    end else if (down_ready) begin
      m_pending = 1'b0;
    end
    m_known = !m_pending || (m_cyc >= W);
  end

  logic phase6 = 1'b0;
  int   ncyc = 0;
  int   last_acc = -1;
  logic prev_busy = 1'b0;

  initial forever begin
    @(negedge clk);
    ncyc++;
    check("up_ready",   32'(up_ready),   32'(!m_pending));
    check("down_valid", 32'(down_valid), 32'(m_pending && (m_cyc == W)));
    check("busy",       32'(busy),       32'(m_pending));
    if (m_known) check("result", 32'(result), 32'(m_res));
    if (phase6 && busy && !prev_busy) begin
      if (last_acc >= 0) check("accept_gap", 32'(ncyc - last_acc), 32'(W + 2));
      last_acc = ncyc;
    end
    prev_busy = busy;
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic [1:0] to,
                       input logic [W-1:0] exp, input int hold);
    int k;
    step();
    up_valid = 1'b1; a = ta; b = tb_b; op = to; down_ready = 1'b0;
    @(posedge clk);
    step();
    up_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 2'($urandom);
    k = 0;
    while (!down_valid && k < W + 5) begin
      step();
      k++;
    end
    check("latency", 32'(k), 32'(W));
    check("literal_result", 32'(result), 32'(exp));
    repeat (hold) step();
    check("hold_up_ready", 32'(up_ready), 32'(0));
    check("hold_result", 32'(result), 32'(exp));
    down_ready = 1'b1;
    step();
    down_ready = 1'b0;
    check("release_idle", 32'(up_ready), 32'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int k;
    logic [31:0] e2;
    repeat (3) step();
    check("rst_up_ready",   32'(up_ready),   32'(1));
    check("rst_down_valid", 32'(down_valid), 32'(0));
    check("rst_busy",       32'(busy),       32'(0));
    check("rst_result",     32'(result),     32'(0));
    rst_n = 1'b1;
    step();

    do_op(8'hA5, 8'h3C, 2'b01, 8'hBD, 0);
    do_op(8'hA5, 8'h3C, 2'b00, 8'h24, 0);
    do_op(8'hA5, 8'h3C, 2'b10, 8'h99, 0);
    do_op(8'hA5, 8'h3C, 2'b11, 8'hDB, 5);

    // reset in the middle of SHIFT
    step();
    up_valid = 1'b1; a = 8'hF0; b = 8'h0F; op = 2'b10;
    @(posedge clk);
    step();
    up_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_up_ready",   32'(up_ready),   32'(1));
    check("midrst_down_valid", 32'(down_valid), 32'(0));
    check("midrst_busy",       32'(busy),       32'(0));
    check("midrst_result",     32'(result),     32'(0));
    step();
    rst_n = 1'b1;
    down_ready = 1'b1;
    repeat (15) step();

    last_acc = -1;
    phase6 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      up_valid = 1'b1; down_ready = 1'b1;
      a = W'($urandom); b = W'($urandom); op = 2'($urandom);
      step();
    end
    phase6 = 1'b0;
    up_valid = 1'b0;
    repeat (12) step();

    for (int i = 0; i < 500; i++) begin
      up_valid   = ($urandom_range(0, 2) != 0);
      down_ready = ($urandom_range(0, 3) == 0);
      a = W'($urandom); b = W'($urandom); op = 2'($urandom);
      step();
    end
    up_valid = 1'b0; down_ready = 1'b1;
    repeat (15) step();

    rst2_n = 1'b1;
    for (int ia = 0; ia < 4; ia++)
      for (int ib = 0; ib < 4; ib++)
        for (int io = 0; io < 4; io++) begin
          step();
          up_valid2 = 1'b1; a2 = 2'(ia); b2 = 2'(ib); op2 = 2'(io);
          @(posedge clk);
          step();
          up_valid2 = 1'b0;
          k = 0;
          while (!down_valid2 && k < 8) begin
            step();
            k++;
          end
          e2 = ref_gate(32'(ia), 32'(ib), 2'(io)) & 32'h3;
          check("w2_result", 32'(result2), e2);
          down_ready2 = 1'b1;
          step();
          down_ready2 = 1'b0;
        end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
